// File: rtl/llc_mem_arbiter_pkg.sv
// Shared constants and types for the LLC-to-memory arbiter and its helpers.
// Field widths match the existing LLC line/address/hprot types.
package llc_mem_arbiter_pkg;

    localparam int LLC_NUM_BANKS = 4;
    localparam int LLC_BANK_BITS = $clog2(LLC_NUM_BANKS);
    localparam int LLC_ADDR_W    = 32;
    localparam int LLC_LINE_W    = 128;
    localparam int LLC_HPROT_W   = 2;

    typedef logic [LLC_ADDR_W-1:0]  line_addr_t;
    typedef logic [LLC_LINE_W-1:0]  line_t;
    typedef logic [LLC_HPROT_W-1:0] hprot_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_t;

    // Index width that stays at least one bit wide for a single-bank build.
    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/llc_rr_picker.sv
// Combinational cyclic priority encoder: first set bit of i_valid at or after i_ptr.
// N must be a power of two so index arithmetic wraps naturally.
module llc_rr_picker #(
    parameter int N  = 4,
    parameter int BW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [BW-1:0] i_ptr,
    output logic [BW-1:0] o_winner,
    output logic          o_any
);

    logic [BW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        // Walk backwards so the candidate closest to i_ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = i_ptr + BW'(k);
            if (i_valid[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among the LLC banks, one transaction in flight.
// state    | meaning
// IDLE     | waiting for any bank request; winner's ready is raised
// ISSUE    | latched request presented on mem_req_* until accepted
// WAIT_RSP | read data routed to the granted bank until it accepts
module llc_mem_arbiter
    import llc_mem_arbiter_pkg::*;
#(
    parameter int NUM_BANKS = LLC_NUM_BANKS,
    parameter int BANK_W    = bank_bits(NUM_BANKS),
    parameter int ADDR_W    = LLC_ADDR_W,
    parameter int LINE_W    = LLC_LINE_W,
    parameter int HPROT_W   = LLC_HPROT_W,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BANKS-1:0]           bank_req_valid,
    output logic [NUM_BANKS-1:0]           bank_req_ready,
    input  logic [NUM_BANKS-1:0]           bank_req_hwrite,
    input  logic [NUM_BANKS*ADDR_W-1:0]    bank_req_addr,
    input  logic [NUM_BANKS*HPROT_W-1:0]   bank_req_hprot,
    input  logic [NUM_BANKS*LINE_W-1:0]    bank_req_line,
    output logic [NUM_BANKS-1:0]           bank_rsp_valid,
    input  logic [NUM_BANKS-1:0]           bank_rsp_ready,
    output logic [LINE_W-1:0]              bank_rsp_line,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_hwrite,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic [HPROT_W-1:0]             mem_req_hprot,
    output logic [LINE_W-1:0]              mem_req_line,
    input  logic                           mem_rsp_valid,
    output logic                           mem_rsp_ready,
    input  logic [LINE_W-1:0]              mem_rsp_line,
    output logic [CNT_W-1:0]               rd_count,
    output logic [CNT_W-1:0]               wr_count
);

    arb_state_t          r_state, w_state_nxt;
    logic [BANK_W-1:0]   r_grant_id, r_rr_ptr, w_winner, w_ptr_nxt;
    logic                w_any_valid;
    logic                r_hwrite;
    logic [ADDR_W-1:0]   r_addr;
    logic [HPROT_W-1:0]  r_hprot;
    logic [LINE_W-1:0]   r_line;
    logic [CNT_W-1:0]    r_rd_count, r_wr_count;
    logic                w_accept, w_issue_done, w_rsp_done;

    llc_rr_picker #(
        .N  (NUM_BANKS),
        .BW (BANK_W)
    ) u_picker (
        .i_valid  (bank_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any_valid)
    );

    assign w_ptr_nxt = (r_grant_id == BANK_W'(NUM_BANKS - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bank_req_ready = '0;
        bank_rsp_valid = '0;
        bank_rsp_line  = '0;
        mem_req_valid  = 1'b0;
        mem_rsp_ready  = 1'b0;
        w_accept       = 1'b0;
        w_issue_done   = 1'b0;
        w_rsp_done     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                bank_req_ready[w_winner] = w_any_valid;
                if (w_any_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_issue_done = 1'b1;
                    w_state_nxt  = r_hwrite ? ARB_IDLE : ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                bank_rsp_valid[r_grant_id] = mem_rsp_valid;
                mem_rsp_ready              = bank_rsp_ready[r_grant_id];
                bank_rsp_line              = mem_rsp_line;
                if (mem_rsp_valid && bank_rsp_ready[r_grant_id]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_hwrite   <= 1'b0;
            r_addr     <= '0;
            r_hprot    <= '0;
            r_line     <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_winner;
                r_hwrite   <= bank_req_hwrite[w_winner];
                r_addr     <= bank_req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                r_hprot    <= bank_req_hprot[int'(w_winner)*HPROT_W +: HPROT_W];
                r_line     <= bank_req_line[int'(w_winner)*LINE_W +: LINE_W];
            end
            // A write completes at the memory handshake; a read only after its response.
            if (w_issue_done) begin
                if (r_hwrite) begin
                    r_rr_ptr <= w_ptr_nxt;
                    if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
                end else begin
                    if (r_rd_count != '1) r_rd_count <= r_rd_count + 1'b1;
                end
            end
            if (w_rsp_done) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign mem_req_hwrite = r_hwrite;
    assign mem_req_addr   = r_addr;
    assign mem_req_hprot  = r_hprot;
    assign mem_req_line   = r_line;
    assign rd_count       = r_rd_count;
    assign wr_count       = r_wr_count;

endmodule

// File: tb/tb_llc_mem_arbiter.sv
// Self-checking bench for llc_mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level round-robin model.
module tb_llc_mem_arbiter;

    localparam int NB   = 4;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int HW   = 2;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NB-1:0]     bank_req_valid  = '0;
    logic [NB-1:0]     bank_req_ready;
    logic [NB-1:0]     bank_req_hwrite = '0;
    logic [NB*AW-1:0]  bank_req_addr   = '0;
    logic [NB*HW-1:0]  bank_req_hprot  = '0;
    logic [NB*LW-1:0]  bank_req_line   = '0;
    logic [NB-1:0]     bank_rsp_valid;
    logic [NB-1:0]     bank_rsp_ready  = '0;
    logic [LW-1:0]     bank_rsp_line;
    logic              mem_req_valid;
    logic              mem_req_ready   = 1'b0;
    logic              mem_req_hwrite;
    logic [AW-1:0]     mem_req_addr;
    logic [HW-1:0]     mem_req_hprot;
    logic [LW-1:0]     mem_req_line;
    logic              mem_rsp_valid   = 1'b0;
    logic              mem_rsp_ready;
    logic [LW-1:0]     mem_rsp_line    = '0;
    logic [CW-1:0]     rd_count;
    logic [CW-1:0]     wr_count;

    llc_mem_arbiter #(
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .LINE_W    (LW),
        .HPROT_W   (HW),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bank_req_valid  (bank_req_valid),
        .bank_req_ready  (bank_req_ready),
        .bank_req_hwrite (bank_req_hwrite),
        .bank_req_addr   (bank_req_addr),
        .bank_req_hprot  (bank_req_hprot),
        .bank_req_line   (bank_req_line),
        .bank_rsp_valid  (bank_rsp_valid),
        .bank_rsp_ready  (bank_rsp_ready),
        .bank_rsp_line   (bank_rsp_line),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_hwrite  (mem_req_hwrite),
        .mem_req_addr    (mem_req_addr),
        .mem_req_hprot   (mem_req_hprot),
        .mem_req_line    (mem_req_line),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_ready   (mem_rsp_ready),
        .mem_rsp_line    (mem_rsp_line),
        .rd_count        (rd_count),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pointer to the bank with highest priority, and stats counts.
    int m_ptr = 0;
    int m_rd  = 0;
    int m_wr  = 0;

    logic [AW-1:0] t_addr  [NB];
    logic [HW-1:0] t_hprot [NB];
    logic [LW-1:0] t_line  [NB];
    logic          directed   = 1'b0;
    logic [LW-1:0] d_rsp_line = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner(input logic [NB-1:0] mask, input int ptr);
        logic [1:0] idx;
        for (int k = 0; k < NB; k++) begin
            idx = 2'(ptr + k);
            if (mask[idx]) return int'(idx);
        end
        return 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v == CMAX) ? v : v + 1;
    endfunction

    // One full transaction; entered and left on a falling edge with the DUT in IDLE.
    task automatic do_round(input logic [NB-1:0] mask, input logic [NB-1:0] wmask,
                            input int req_wait, input int rsp_wait, input int stall,
                            output int win);
        logic [1:0]    wi;
        logic [NB-1:0] onehot;
        logic [NB-1:0] rdy;
        logic [LW-1:0] rline;
        for (int b = 0; b < NB; b++) begin
            if (!directed) begin
                t_addr[b]  = $urandom;
                t_hprot[b] = 2'($urandom);
                t_line[b]  = {$urandom, $urandom, $urandom, $urandom};
            end
            bank_req_addr[b*AW +: AW]  = t_addr[b];
            bank_req_hprot[b*HW +: HW] = t_hprot[b];
            bank_req_line[b*LW +: LW]  = t_line[b];
        end
        bank_req_valid  = mask;
        bank_req_hwrite = wmask;
        win    = exp_winner(mask, m_ptr);
        wi     = 2'(win);
        onehot = NB'(1) << wi;
        #1;
        chk("idle_req_ready", 128'(bank_req_ready), 128'(onehot));
        chk("idle_mem_valid", 128'(mem_req_valid), 128'(0));
        @(negedge clk);
        for (int c = 0; c <= req_wait; c++) begin
            mem_req_ready = (c == req_wait);
            #1;
            chk("issue_valid",  128'(mem_req_valid),  128'(1));
            chk("issue_addr",   128'(mem_req_addr),   128'(t_addr[wi]));
            chk("issue_hwrite", 128'(mem_req_hwrite), 128'(wmask[wi]));
            chk("issue_hprot",  128'(mem_req_hprot),  128'(t_hprot[wi]));
            chk("issue_line",   128'(mem_req_line),   128'(t_line[wi]));
            chk("issue_no_rdy", 128'(bank_req_ready), 128'(0));
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        if (wmask[wi]) begin
            m_wr  = sat_inc(m_wr);
            m_ptr = (win + 1) % NB;
        end else begin
            m_rd  = sat_inc(m_rd);
            rline = directed ? d_rsp_line : {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < rsp_wait; c++) begin
                bank_rsp_ready = NB'($urandom);
                mem_rsp_valid  = 1'b0;
                #1;
                chk("wait_rsp_valid", 128'(bank_rsp_valid), 128'(0));
                chk("wait_rsp_ready", 128'(mem_rsp_ready),  128'(bank_rsp_ready[wi]));
                chk("wait_no_rdy",    128'(bank_req_ready), 128'(0));
                @(negedge clk);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_line  = rline;
            for (int c = 0; c <= stall; c++) begin
                rdy            = NB'($urandom);
                rdy[wi]        = (c == stall);
                bank_rsp_ready = rdy;
                #1;
                chk("rsp_valid",  128'(bank_rsp_valid), 128'(onehot));
                chk("rsp_ready",  128'(mem_rsp_ready),  128'(c == stall));
                chk("rsp_line",   128'(bank_rsp_line),  128'(rline));
                chk("rsp_no_rdy", 128'(bank_req_ready), 128'(0));
                @(negedge clk);
            end
            mem_rsp_valid  = 1'b0;
            bank_rsp_ready = '0;
            m_ptr = (win + 1) % NB;
        end
        bank_req_valid = '0;
        #1;
        chk("rd_count", 128'(rd_count), 128'(m_rd));
        chk("wr_count", 128'(wr_count), 128'(m_wr));
    endtask

    initial begin
        int win;
        int rounds;
        #2;
        chk("rst_req_ready", 128'(bank_req_ready), 128'(0));
        chk("rst_mem_valid", 128'(mem_req_valid),  128'(0));
        chk("rst_rsp_ready", 128'(mem_rsp_ready),  128'(0));
        chk("rst_rsp_valid", 128'(bank_rsp_valid), 128'(0));
        chk("rst_counts",    128'({rd_count, wr_count}), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // Fairness: all banks writing continuously.
        for (int i = 0; i < 5; i++) begin
            do_round(4'hF, 4'hF, 0, 0, 0, win);
            chk("fair_order", 128'(win), 128'(i % NB));
        end
        chk("fair_wr5", 128'(wr_count), 128'(5));

        // Single read from bank 2.
        directed   = 1'b1;
        t_addr[2]  = 32'h0000_1000;
        t_hprot[2] = 2'b01;
        t_line[2]  = '0;
        d_rsp_line = {16{8'hA5}};
        do_round(4'b0100, 4'b0000, 0, 1, 0, win);
        chk("single_rd1", 128'(rd_count), 128'(1));
        directed = 1'b0;

        // Response stall to bank 1 while bank 2 keeps requesting.
        do_round(4'b0110, 4'b0000, 0, 0, 3, win);

        // Memory back-pressure for 7 cycles with other banks waiting.
        do_round(4'hF, 4'b0101, 7, 1, 1, win);

        // Stray response in IDLE is held off.
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = {4{32'hDEAD_BEEF}};
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stray_rsp_ready", 128'(mem_rsp_ready),  128'(0));
            chk("stray_rsp_valid", 128'(bank_rsp_valid), 128'(0));
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;

        // Random traffic until both counters saturate, then a bit more.
        rounds = 0;
        while (rounds < 600 && (m_rd < CMAX || m_wr < CMAX || rounds < 40)) begin
            do_round(NB'($urandom_range(1, 15)), NB'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), win);
            rounds++;
        end
        do_round(4'b1000, 4'b0000, 1, 0, 0, win);
        chk("rd_saturated", 128'(rd_count), 128'(CMAX));
        do_round(4'b0001, 4'b0001, 0, 0, 0, win);
        chk("wr_saturated", 128'(wr_count), 128'(CMAX));

        // Reset while a request is being issued.
        bank_req_valid  = 4'b0100;
        bank_req_hwrite = 4'b0000;
        @(negedge clk);
        #1;
        chk("pre_rst_issue", 128'(mem_req_valid), 128'(1));
        rst            = 1'b0;
        bank_req_valid = '0;
        #1;
        chk("rst_mid_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_mid_rd",    128'(rd_count),      128'(0));
        chk("rst_mid_wr",    128'(wr_count),      128'(0));
        chk("rst_mid_addr",  128'(mem_req_addr),  128'(0));
        @(negedge clk);
        rst   = 1'b1;
        m_ptr = 0;
        m_rd  = 0;
        m_wr  = 0;
        do_round(4'hF, 4'b0000, 0, 0, 0, win);
        chk("post_rst_win0", 128'(bank_rsp_valid), 128'(0));
        do_round(4'hF, 4'hF, 0, 0, 0, win);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/llc_mem_arbiter.md
Name: llc_mem_arbiter

Overview:
- Shares one off-chip memory port among NUM_BANKS llc_core instances in a multi-bank LLC.
- Each bank's llc_mem_req / llc_mem_rsp channel terminates here.
- Round-robin arbitration; one transaction in flight at a time.
- Read data is routed back only to the issuing bank. Saturating read/write counters support stats.

Parameters:
- NUM_BANKS, 4, number of LLC banks; power of two, 2..16.
- BANK_W, $clog2(NUM_BANKS), bank index width.
- ADDR_W, 32, line address width.
- LINE_W, 128, cache line width.
- HPROT_W, 2, hprot width.
- CNT_W, 16, stats counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- bank_req_valid  in  NUM_BANKS  per-bank memory request valid
- bank_req_ready  out  NUM_BANKS  per-bank memory request ready
- bank_req_hwrite  in  NUM_BANKS  1 = write-back, 0 = read
- bank_req_addr  in  NUM_BANKS*ADDR_W  line address
- bank_req_hprot  in  NUM_BANKS*HPROT_W  hprot
- bank_req_line  in  NUM_BANKS*LINE_W  write data
- bank_rsp_valid  out  NUM_BANKS  per-bank read response valid
- bank_rsp_ready  in  NUM_BANKS  per-bank read response ready
- bank_rsp_line  out  LINE_W  read data, broadcast to all banks, qualified by bank_rsp_valid
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request ready
- mem_req_hwrite  out  1  request type
- mem_req_addr  out  ADDR_W  line address
- mem_req_hprot  out  HPROT_W  hprot
- mem_req_line  out  LINE_W  write data
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_ready  out  1  memory response ready
- mem_rsp_line  in  LINE_W  read data
- rd_count  out  CNT_W  reads issued, saturating
- wr_count  out  CNT_W  writes issued, saturating

Behaviour:
- FSM states: IDLE, ISSUE, WAIT_RSP. Reset state IDLE.
- Registers reset to 0: grant_id, rr_ptr, all latched request fields, rd_count, wr_count.
- All outputs are 0 during and after reset until the FSM acts.
- Winner: first index i with bank_req_valid[i], searching cyclically from rr_ptr. Combinational.
- IDLE:
  - bank_req_ready[winner] = 1 only if any valid; all other readies 0.
  - On the accept handshake: latch hwrite/addr/hprot/line and grant_id = winner; go to ISSUE.
  - No request -> stay in IDLE.
- ISSUE:
  - mem_req_* driven from the latched registers; mem_req_valid = 1.
  - Valid held stable until mem_req_ready.
  - On handshake with write: wr_count++ (saturating); rr_ptr = grant_id+1 mod NUM_BANKS; go to IDLE.
  - On handshake with read: rd_count++ (saturating); go to WAIT_RSP.
- WAIT_RSP:
  - bank_rsp_valid[grant_id] = mem_rsp_valid; mem_rsp_ready = bank_rsp_ready[grant_id]; bank_rsp_line = mem_rsp_line.
  - On handshake: rr_ptr = grant_id+1 mod NUM_BANKS; go to IDLE.
- mem_rsp_ready = 0 outside WAIT_RSP; a stray response is back-pressured, never dropped.
- bank_rsp_valid is 0 for every non-granted bank and outside WAIT_RSP.
- Latency:
  - Accept at cycle T -> mem_req_valid at T+1.
  - Write fully done -> next accept possible the cycle after the mem handshake.
  - Read -> next accept the cycle after the response handshake.
- rr_ptr advances only on transaction completion, so a bank granted once cannot win again while others wait.
- Counters hold at all-ones; no wrap.
- Bank valid dropped while not granted: ignored, no state change.
- Async reset mid-transaction: return to IDLE, all state cleared; the in-flight transaction is abandoned.
- NUM_BANKS=1: degenerates to a one-register pass-through with the same latency.

Decomposition:
- Shared package (cache_consts/cache_types):
  - LLC_NUM_BANKS, LLC_BANK_BITS constants.
  - arb state enum typedef.
  - Existing line_addr_t, line_t, hprot_t reused for field widths.
- One sub-module: llc_rr_picker (combinational cyclic priority encoder: valid vector + rr_ptr -> winner index, any_valid). Reused by future DMA/bank arbiters.

Test Plan:
- Single read: bank 2 read addr 0x1000 at T -> mem_req_valid T+1 with addr 0x1000, hwrite 0. Response line 0xA5.. -> bank_rsp_valid[2] only, line 0xA5..; rd_count=1.
- Fairness: all 4 banks hold writes continuously, mem_req_ready=1 -> grant order 0,1,2,3,0; wr_count=5 after 5 handshakes.
- Back-pressure: mem_req_ready low for 7 cycles -> mem_req fields stable, no bank_req_ready asserted, no second accept.
- Response stall: in WAIT_RSP with bank_rsp_ready[1]=0 for 3 cycles -> mem_rsp_ready=0, bank_rsp_valid[1] held; other banks' valid requests not accepted.
- Stray response: mem_rsp_valid=1 in IDLE -> mem_rsp_ready=0, all bank_rsp_valid=0.
- Saturation and reset: preload rd_count to 0xFFFF via 65535 reads -> next read keeps 0xFFFF. Assert rst in ISSUE -> mem_req_valid=0 immediately, counters 0, state IDLE.
